down_counter_timer: RTL and testbench
=====================================

// Module: down_counter_timer
// PURPOSE
//  Loadable down-counter/timer; the decrementing counterpart to the team's free-running up-counter.
//  Software or an FSM loads a count and starts it. The block decrements once per prescaled tick.
//  It pulses done on reaching zero and optionally auto-reloads.
//  Used for Lab timing/delay generation alongside the up-counter blocks.
// PARAMETERS
//  WIDTH     4  counter/load width in bits (>=2)
//  PRESCALE  1  clk cycles per decrement (>=1); 1 = decrement every cycle
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  rst          in   1      reset: synchronous, active-low (rst==0 resets on posedge clk)
//  load         in   1      pulse: capture load_val into count and reload register
//  load_val     in   WIDTH  value captured by load
//  start        in   1      pulse: begin counting from current count
//  pause        in   1      level: freeze counting while high
//  auto_reload  in   1      level: on terminal tick reload instead of stopping
//  count        out  WIDTH  current count (registered)
//  busy         out  1      high in RUN or PAUSED
//  done         out  1      one-cycle pulse on terminal tick
// BEHAVIOUR
//  Reset (rst==0 at posedge): count=0, reload_reg=0, busy=0, done=0, state=IDLE, prescaler=0.
//  States: IDLE, RUN, PAUSED. busy = (state != IDLE). done defaults to 0 every cycle.
//  Priority per edge: rst > load > pause > start > tick.
//  load (any state): count<=load_val; reload_reg<=load_val; state<=IDLE; prescaler<=0.
//    It aborts an active run. No done pulse.
//  IDLE: start && count!=0 -> RUN, prescaler<=0.
//    start && count==0 is ignored: stays IDLE, no done.
//  RUN:
//    pause=1 -> PAUSED; prescaler and count hold.
//    Otherwise prescaler increments; tick when prescaler==PRESCALE-1, then prescaler<=0.
//    Non-terminal tick (count>1): count<=count-1.
//    Terminal tick (count==1):
//      done<=1 in the same edge.
//      auto_reload=1: count<=reload_reg, stay RUN.
//      auto_reload=0: count<=0, state<=IDLE.
//    start while RUN: ignored.
//  PAUSED: pause=0 -> RUN, resuming from the frozen prescaler/count.
//    start is ignored. load still applies.
//  Latency: start sampled at edge k -> first decrement at edge k+PRESCALE.
//    Loaded N -> done high in the cycle after edge k+N*PRESCALE; count reads 0 in that same cycle.
//  Arithmetic: unsigned WIDTH bits. count never wraps below 0.
//    Max load 2^WIDTH-1 counts that many ticks.
//  Auto-reload with reload_reg==... (N>=1 guaranteed, since start needs count!=0):
//    period is exactly N*PRESCALE cycles. done pulses once per period.
//  Reset mid-run: identical to power-on reset on that edge; no done.
//  pause and terminal tick in the same cycle: pause wins, no decrement, no done.
// STRUCTURE
//  timer_defs.vh: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSED=2'd2.
//  Sub-module tick_gen #(PRESCALE): prescaler counter.
//    Inputs: clk, rst, en, clr. Output: tick.
//    Counter width is $clog2(PRESCALE), minimum 1. When PRESCALE==1, tick=en.
//  Top module holds the FSM, count and reload_reg. Unused encoding 2'd3 recovers to IDLE.
// TESTING
//  1 Reset: hold rst=0 for 2 cycles with random inputs -> count=0, busy=0, done=0.
//  2 WIDTH=4, PRESCALE=1: load 5, start.
//    -> count 5,4,3,2,1,0 on consecutive cycles; done high exactly 1 cycle when count=0.
//    -> busy drops the same edge.
//  3 PRESCALE=3: load 2, start.
//    -> done 6 cycles after start edge.
//    -> pause for 4 cycles mid-run extends done by exactly 4 cycles.
//  4 auto_reload=1: load 3, start, run 12 cycles.
//    -> done pulses every 3 cycles (4 pulses); count sequence 3,2,1,3,2,1...
//  5 Corner cases:
//    start with count=0 -> no busy, no done.
//    load 9 during RUN at count=2 -> IDLE, count=9, no done.
//    load 15 -> 15 ticks to done.
//  6 rst=0 asserted while count=1 and tick pending -> count=0, done stays 0, IDLE.

Source files
------------

// File: rtl/down_counter_timer_pkg.sv
// Shared types and helpers for the down-counter/timer.
package down_counter_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

  // Prescaler counter width: enough bits for PRESCALE-1, never less than one.
  function automatic int unsigned prescale_width(input int unsigned prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/down_counter_timer_tick_gen.sv
// Prescaler: asserts tick on every PRESCALE-th enabled cycle.
module down_counter_timer_tick_gen
  import down_counter_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = prescale_width(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // With PRESCALE==1 the counter sits at zero, so tick follows en directly.
  assign tick = en && (cnt == LAST);

  // Phase counter; holds while disabled so a pause freezes the phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with pause, done pulse and optional auto-reload.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_e           state;
  state_e           state_n;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_n;
  logic [WIDTH-1:0] count_n;
  logic             busy_n;
  logic             done_n;
  logic             active;
  logic             tick;
  logic             tick_en;
  logic             tick_clr;

  // Prescaler advances only while counting; it restarts from zero outside a run.
  assign active   = (state == ST_RUN) || (state == ST_PAUSED);
  assign tick_en  = active && !pause && !load;
  assign tick_clr = load || !active;

  down_counter_timer_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (tick_en),
    .clr (tick_clr),
    .tick(tick)
  );

  // Next-state, count and done decode; load outranks pause, pause outranks start/tick.
  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload_reg;
    done_n   = 1'b0;
    if (load) begin
      count_n  = load_val;
      reload_n = load_val;
      state_n  = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!pause && start && (count != '0)) begin
            state_n = ST_RUN;
          end
        end
        ST_RUN, ST_PAUSED: begin
          if (pause) begin
            state_n = ST_PAUSED;
          end else begin
            // Releasing pause counts on that same edge, so a pause costs exactly its length.
            state_n = ST_RUN;
            if (tick) begin
              if (count == WIDTH'(1)) begin
                done_n = 1'b1;
                if (auto_reload) begin
                  count_n = reload_reg;
                end else begin
                  count_n = '0;
                  state_n = ST_IDLE;
                end
              end else if (count != '0) begin
                count_n = count - WIDTH'(1);
              end
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
    busy_n = (state_n != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      reload_reg <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_reg <= reload_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: two instances (PRESCALE 1 and 3) on shared stimulus.
module tb_down_counter_timer;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         pause;
  logic         auto_reload;
  logic [W-1:0] count1;
  logic [W-1:0] count3;
  logic         busy1;
  logic         busy3;
  logic         done1;
  logic         done3;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, index 0 -> PRESCALE 1, index 1 -> PRESCALE 3.
  // m_st: 0 idle, 1 running, 2 paused. m_phase: cycles elapsed in current tick period.
  int presc[2] = '{1, 3};
  int m_count[2];
  int m_reload[2];
  int m_st[2];
  int m_phase[2];
  int m_done[2];

  always #5 clk = ~clk;

  down_counter_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .auto_reload(auto_reload), .count(count1), .busy(busy1), .done(done1)
  );

  down_counter_timer #(.WIDTH(W), .PRESCALE(3)) dut3 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .auto_reload(auto_reload), .count(count3), .busy(busy3), .done(done3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    if (obs !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One edge of the behavioural model, using the inputs currently driven.
  task automatic model_step(input int i);
    m_done[i] = 0;
    if (!rst) begin
      m_count[i] = 0; m_reload[i] = 0; m_st[i] = 0; m_phase[i] = 0;
    end else if (load) begin
      m_count[i] = int'(load_val); m_reload[i] = int'(load_val);
      m_st[i] = 0; m_phase[i] = 0;
    end else if (m_st[i] == 0) begin
      if (!pause && start && m_count[i] != 0) begin
        m_st[i] = 1; m_phase[i] = 0;
      end
    end else if (pause) begin
      m_st[i] = 2;
    end else begin
      m_st[i] = 1;
      m_phase[i]++;
      if (m_phase[i] == presc[i]) begin
        m_phase[i] = 0;
        if (m_count[i] == 1) begin
          m_done[i] = 1;
          if (auto_reload) m_count[i] = m_reload[i];
          else begin
            m_count[i] = 0; m_st[i] = 0;
          end
        end else begin
          m_count[i] = m_count[i] - 1;
        end
      end
    end
  endtask

  // Drive inputs, advance one clock, compare both instances against the model.
  task automatic cycle(input logic r, input logic l, input logic [W-1:0] lv,
                       input logic s, input logic p, input logic a);
    rst = r; load = l; load_val = lv; start = s; pause = p; auto_reload = a;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check("count_p1", 32'(count1), m_count[0]);
    check("busy_p1",  32'(busy1),  (m_st[0] != 0) ? 1 : 0);
    check("done_p1",  32'(done1),  m_done[0]);
    check("count_p3", 32'(count3), m_count[1]);
    check("busy_p3",  32'(busy3),  (m_st[1] != 0) ? 1 : 0);
    check("done_p3",  32'(done3),  m_done[1]);
  endtask

  task automatic idle(input logic p, input logic a);
    cycle(1'b1, 1'b0, '0, 1'b0, p, a);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    cycle(1'b1, 1'b1, v, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_start(input logic a);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, a);
  endtask

  initial begin
    int found;
    int pulses;
    logic ar;
    rst = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0; auto_reload = 1'b0;

    // Reset held two cycles with random other inputs.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    check("rst_count", 32'(count1), 0);
    check("rst_busy",  32'(busy1),  0);
    check("rst_done",  32'(done3),  0);

    // PRESCALE 1: load 5, start, count down to zero.
    do_load(W'(5));
    do_start(1'b0);
    check("t2_busy_start", 32'(busy1), 1);
    for (int i = 1; i <= 5; i++) begin
      idle(1'b0, 1'b0);
      check("t2_count", 32'(count1), 5 - i);
      check("t2_done",  32'(done1),  (i == 5) ? 1 : 0);
      check("t2_busy",  32'(busy1),  (i < 5) ? 1 : 0);
    end
    idle(1'b0, 1'b0);
    check("t2_done_once", 32'(done1), 0);

    // PRESCALE 3: load 2, start, pause four cycles mid-run.
    do_load(W'(2));
    do_start(1'b0);
    found = 0;
    for (int i = 1; i <= 20; i++) begin
      idle((i >= 2 && i <= 5), 1'b0);
      if (done3 && found == 0) found = i;
    end
    check("t3_done_latency", 32'(found), 10);

    // Auto-reload period with PRESCALE 1.
    do_load(W'(3));
    do_start(1'b1);
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      idle(1'b0, 1'b1);
      check("t4_count", 32'(count1), 3 - (i % 3));
      if (done1) pulses++;
    end
    check("t4_pulses", 32'(pulses), 4);

    // Start with count zero is ignored.
    do_load('0);
    do_start(1'b0);
    check("t5_zero_busy", 32'(busy1), 0);
    check("t5_zero_done", 32'(done1), 0);

    // Load during a run aborts it.
    do_load(W'(5));
    do_start(1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b0);
    check("t5_pre_abort", 32'(count1), 2);
    do_load(W'(9));
    check("t5_abort_count", 32'(count1), 9);
    check("t5_abort_busy",  32'(busy1),  0);
    check("t5_abort_done",  32'(done1),  0);

    // Maximum load counts 15 ticks.
    do_load(W'(15));
    do_start(1'b0);
    found = 0;
    for (int i = 1; i <= 20; i++) begin
      idle(1'b0, 1'b0);
      if (done1 && found == 0) found = i;
    end
    check("t5_max_latency", 32'(found), 15);

    // Reset on the edge a terminal tick is due.
    do_load(W'(1));
    do_start(1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("t6_count", 32'(count3), 0);
    check("t6_done",  32'(done3),  0);
    check("t6_busy",  32'(busy3),  0);

    // Randomized stimulus against the model.
    ar = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 15) == 0), W'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), ar);
      if ($urandom_range(0, 49) == 0) ar = ~ar;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
